// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
package display_scan_ctrl_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_ALL   = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b1111110;

    // Counter/index width that stays at least one bit for tiny ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Datapath-side and pin-side signals of the display scan controller.
interface display_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] Digits;
    logic                  Load;
    logic                  LZ_EN;
    logic                  LT;
    logic                  BI;
    logic [6:0]            Seg;
    logic [N_DIGITS-1:0]   An;
    logic                  Frame;

    modport master (
        output Digits, Load, LZ_EN, LT, BI,
        input  Seg, An, Frame
    );

    modport slave (
        input  Digits, Load, LZ_EN, LT, BI,
        output Seg, An, Frame
    );
endinterface

// File: rtl/bcd7seg_dec.sv
// Combinational BCD to 7-segment {a..g} decoder with lamp-test and blanking.
module bcd7seg_dec
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       lt,
    input  logic       bi_n,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_ZERO;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1110011;
            default: seg = SEG_ZERO;
        endcase
        if (!bi_n) seg = SEG_BLANK;
        // Lamp test wins over blanking so a dark display can still be checked.
        if (lt) seg = SEG_ALL;
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan with frame-synchronous double buffer,
// leading-zero suppression and a per-slot anti-ghosting guard.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave dsp
);

    localparam int IDX_W = idx_width(N_DIGITS);
    localparam int PS_W  = idx_width(PRESCALE);

    logic [PS_W-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_q, pend_d;
    logic [4*N_DIGITS-1:0] act_q, act_d;
    seg_t                  seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  slot_end;
    logic                  wrap;
    logic                  in_guard;
    logic [3:0]            nib;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  zero_run;
    logic                  lz_blank;
    logic                  bi_eff_n;
    seg_t                  dec_seg;

    always_comb begin
        slot_end = (presc_q == PS_W'(PRESCALE - 1));
        wrap     = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));
        presc_d  = slot_end ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;
        // Active only changes at the frame boundary, so a frame never tears.
        act_d    = wrap ? pend_q : act_q;
        pend_d   = dsp.Load ? dsp.Digits : pend_q;
        frame_d  = wrap;
    end

    always_comb begin
        nib = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) nib = act_q[4*i +: 4];
        end
    end

    // lz_mask[i] is set when digits N_DIGITS-1 down to i are all zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (act_q[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
        lz_blank = dsp.LZ_EN && lz_mask[idx_q];
        bi_eff_n = dsp.BI && !lz_blank;
    end

    bcd7seg_dec u_dec (
        .bcd  (nib),
        .lt   (dsp.LT),
        .bi_n (bi_eff_n),
        .seg  (dec_seg)
    );

    always_comb begin
        in_guard = (32'(presc_q) < 32'(GUARD));
        an_d     = in_guard ? '0 : (N_DIGITS'(1) << idx_q);
        seg_d    = in_guard ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign dsp.Seg   = seg_q;
    assign dsp.An    = an_q;
    assign dsp.Frame = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a cycle model feeding a scoreboard queue.
module tb_display_scan_ctrl;
    import display_scan_ctrl_pkg::*;

    localparam int N = 4;
    localparam int P = 4;
    localparam int G = 1;

    logic clk = 1'b0;
    logic rst_n;

    display_scan_ctrl_if #(.N_DIGITS(N)) dsp ();

    display_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .GUARD(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dsp   (dsp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]   seg;
        logic [N-1:0] an;
        logic         frame;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          m_p = 0, m_i = 0;
    logic [15:0] m_pend = '0, m_act = '0;
    logic        m_frame = 1'b0;
    int          n_cyc;

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1110011;
            default: return 7'b1111110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: predict outputs from the model state, advance the model on the edge,
    // then compare the DUT against the queued prediction on the falling edge.
    task automatic tick();
        exp_t       e;
        logic       lz;
        logic       wrapped;
        e = '0;
        if (rst_n && m_p >= G) begin
            e.an = N'(1) << m_i;
            lz = dsp.LZ_EN && (m_i > 0);
            for (int k = m_i; k < N; k++) if (m_act[4*k +: 4] != 4'd0) lz = 1'b0;
            if (dsp.LT)                e.seg = SEG_ALL;
            else if (!dsp.BI || lz)    e.seg = SEG_BLANK;
            else                       e.seg = ref_dec(m_act[4*m_i +: 4]);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_p = 0; m_i = 0; m_pend = '0; m_act = '0; m_frame = 1'b0;
        end else begin
            wrapped = (m_p == P - 1) && (m_i == N - 1);
            if (wrapped) m_act = m_pend;
            if (dsp.Load) m_pend = dsp.Digits;
            m_frame = wrapped;
            if (m_p == P - 1) begin
                m_p = 0;
                m_i = wrapped ? 0 : m_i + 1;
            end else begin
                m_p = m_p + 1;
            end
        end
        e.frame = m_frame;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check("sb_seg",   16'(dsp.Seg),   16'(e.seg));
        check("sb_an",    16'(dsp.An),    16'(e.an));
        check("sb_frame", 16'(dsp.Frame), 16'(e.frame));
    endtask

    task automatic load(input logic [15:0] v);
        dsp.Digits = v;
        dsp.Load   = 1'b1;
        tick();
        dsp.Load   = 1'b0;
    endtask

    task automatic wait_frame(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!dsp.Frame && n < max);
        check("frame_seen", 16'(dsp.Frame), 16'd1);
    endtask

    // Walks one whole frame starting right after a Frame pulse, checking against constants.
    task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input int load_at, input logic [15:0] load_val);
        logic [6:0] es [4];
        int slot, cyc;
        es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
        for (int j = 0; j < N * P; j++) begin
            slot = j / P;
            cyc  = j % P;
            if (j == load_at) begin
                dsp.Digits = load_val;
                dsp.Load   = 1'b1;
            end
            tick();
            dsp.Load = 1'b0;
            check({tag, "_an"},  16'(dsp.An),  (cyc < G) ? 16'd0 : 16'(1 << slot));
            check({tag, "_seg"}, 16'(dsp.Seg), (cyc < G) ? 16'd0 : 16'(es[slot]));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        dsp.Digits = '0;
        dsp.Load   = 1'b0;
        dsp.LZ_EN  = 1'b0;
        dsp.LT     = 1'b0;
        dsp.BI     = 1'b1;

        tick();
        check("rst_seg",   16'(dsp.Seg),   16'd0);
        check("rst_an",    16'(dsp.An),    16'd0);
        check("rst_frame", 16'(dsp.Frame), 16'd0);
        tick();

        // 1: plain decode of 1234
        rst_n = 1'b1;
        load(16'h1234);
        wait_frame(40, n_cyc);
        check("first_frame_delay", 16'(n_cyc), 16'd15);
        check_frame("t1", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, -1, '0);

        // 2: leading-zero suppression of 0050
        dsp.LZ_EN = 1'b1;
        load(16'h0050);
        wait_frame(40, n_cyc);
        check_frame("t2", 7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000, -1, '0);

        // 3: all zeros keeps only digit 0
        load(16'h0000);
        wait_frame(40, n_cyc);
        check_frame("t3", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000, -1, '0);

        // 4: lamp test overrides blanking, release takes one cycle
        dsp.LT = 1'b1;
        dsp.BI = 1'b0;
        load(16'h1234);
        wait_frame(40, n_cyc);
        check_frame("t4", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, -1, '0);
        tick();
        tick();
        check("lt_hold_seg", 16'(dsp.Seg), 16'h007f);
        dsp.LT = 1'b0;
        tick();
        check("lt_release_seg", 16'(dsp.Seg), 16'd0);
        check("lt_release_an",  16'(dsp.An),  16'd1);
        dsp.BI = 1'b1;

        // 5: mid-frame load is deferred to the next frame
        wait_frame(40, n_cyc);
        check_frame("t5a", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, P * 2 + 1, 16'h9999);
        check_frame("t5b", 7'b1110011, 7'b1110011, 7'b1110011, 7'b1110011, -1, '0);

        // 6: reset in slot 2 cycle 2 restarts the scan with empty buffers
        dsp.LZ_EN = 1'b0;
        for (int k = 0; k < P * 2 + 2; k++) tick();
        rst_n = 1'b0;
        tick();
        check("t6_rst_seg",   16'(dsp.Seg),   16'd0);
        check("t6_rst_an",    16'(dsp.An),    16'd0);
        check("t6_rst_frame", 16'(dsp.Frame), 16'd0);
        rst_n = 1'b1;
        wait_frame(40, n_cyc);
        check("t6_frame_delay", 16'(n_cyc), 16'(N * P));
        check_frame("t6", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, -1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
